// File: rtl/bcd_field_editor.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_field_editor
//  Description : Button-driven editor for a packed row of 2-digit BCD fields
//                with cursor selection, wrap-around limits and auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_field_editor #(
    parameter int NFIELDS       = 3,
    parameter int FIRST_MAX     = 23,
    parameter int OTHER_MAX     = 59,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        EN,
    input  logic                                        BTup,
    input  logic                                        BTdown,
    input  logic                                        BTl,
    input  logic                                        BTr,
    input  logic [8*NFIELDS-1:0]                        din,
    output logic [8*NFIELDS-1:0]                        dout,
    output logic [((NFIELDS > 1) ? $clog2(NFIELDS) : 1)-1:0] cursor,
    output logic                                        changed
);

    localparam int CW      = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNTW-1:0] HOLD_C = CNTW'(HOLD_CYCLES);
    localparam logic [CNTW-1:0] REP_C  = CNTW'(REPEAT_CYCLES);

    localparam logic [7:0] FIRST_BCD = 8'(((FIRST_MAX / 10) * 16) + (FIRST_MAX % 10));
    localparam logic [7:0] OTHER_BCD = 8'(((OTHER_MAX / 10) * 16) + (OTHER_MAX % 10));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EDIT = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [8*NFIELDS-1:0] dout_q,    dout_d;
    logic [CW-1:0]        cursor_q,  cursor_d;
    logic                 changed_q, changed_d;
    logic [CNTW-1:0]      cnt_q,     cnt_d;
    logic                 rep_q,     rep_d;
    logic [3:0]           prev_q,    prev_d;

    logic up_p, dn_p, l_p, r_p, do_step;

    // A valid BCD byte compares numerically like its decimal value, so the
    // range check can be done directly on the packed digits.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] max_bcd);
        logic [3:0] t;
        logic [3:0] u;
        logic [7:0] r;
        t = v[7:4];
        u = v[3:0];
        if ((t > 4'd9) || (u > 4'd9) || (v > max_bcd)) begin
            r = up ? 8'h00 : max_bcd;
        end else if (up) begin
            if (v == max_bcd)   r = 8'h00;
            else if (u == 4'd9) r = {t + 4'd1, 4'd0};
            else                r = {t, u + 4'd1};
        end else begin
            if (v == 8'h00)     r = max_bcd;
            else if (u == 4'd0) r = {t - 4'd1, 4'd9};
            else                r = {t, u - 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            dout_q    <= '0;
            cursor_q  <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
            rep_q     <= 1'b0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            cursor_q  <= cursor_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            prev_q    <= prev_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = EN ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_EDIT;
            S_EDIT:  state_d = S_EDIT;
            default: state_d = S_IDLE;
        endcase
        if (!EN) state_d = S_IDLE;
    end

    assign up_p = BTup   & ~prev_q[0];
    assign dn_p = BTdown & ~prev_q[1];
    assign l_p  = BTl    & ~prev_q[2];
    assign r_p  = BTr    & ~prev_q[3];

    always_comb begin
        dout_d    = dout_q;
        cursor_d  = cursor_q;
        changed_d = 1'b0;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        prev_d    = {BTr, BTl, BTdown, BTup};
        do_step   = 1'b0;

        case (state_q)
            S_LOAD: begin
                dout_d   = din;
                cursor_d = '0;
                cnt_d    = '0;
                rep_d    = 1'b0;
            end
            S_EDIT: begin
                // The counter only runs after a genuine press; a level held
                // through entry or past a cursor move never starts repeating.
                if (BTup && BTdown) begin
                    cnt_d = '0;
                    rep_d = 1'b0;
                end else if (up_p || dn_p) begin
                    do_step = 1'b1;
                    cnt_d   = CNTW'(1);
                    rep_d   = 1'b0;
                end else if ((BTup ^ BTdown) && (cnt_q != '0)) begin
                    if (cnt_q == (rep_q ? REP_C : HOLD_C)) begin
                        do_step = 1'b1;
                        cnt_d   = CNTW'(1);
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                    rep_d = 1'b0;
                end

                for (int i = 0; i < NFIELDS; i++) begin
                    if (do_step && (cursor_q == CW'(i))) begin
                        dout_d[8*(NFIELDS-1-i) +: 8] =
                            bcd_step(dout_q[8*(NFIELDS-1-i) +: 8], BTup,
                                     (i == 0) ? FIRST_BCD : OTHER_BCD);
                    end
                end
                changed_d = do_step;

                if (l_p ^ r_p) begin
                    cnt_d = '0;
                    rep_d = 1'b0;
                    if (r_p) cursor_d = (cursor_q == CW'(NFIELDS-1)) ? '0 : cursor_q + 1'b1;
                    else     cursor_d = (cursor_q == '0) ? CW'(NFIELDS-1) : cursor_q - 1'b1;
                end
            end
            default: begin
                cursor_d = '0;
                cnt_d    = '0;
                rep_d    = 1'b0;
            end
        endcase

        if (!EN) begin
            dout_d    = dout_q;
            cursor_d  = '0;
            changed_d = 1'b0;
            cnt_d     = '0;
            rep_d     = 1'b0;
        end
    end

    always_comb begin
        dout    = dout_q;
        cursor  = cursor_q;
        changed = changed_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_field_editor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_field_editor
//  Description : Self-checking bench with a cycle-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_field_editor;

    localparam int N    = 3;
    localparam int FMAX = 23;
    localparam int OMAX = 59;
    localparam int HOLD = 4;
    localparam int REP  = 2;

    logic          clk = 1'b0;
    logic          reset, EN, BTup, BTdown, BTl, BTr;
    logic [8*N-1:0] din;
    logic [8*N-1:0] dout;
    logic [1:0]    cursor;
    logic          changed;

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;

    bcd_field_editor #(
        .NFIELDS(N), .FIRST_MAX(FMAX), .OTHER_MAX(OMAX),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset), .EN(EN), .BTup(BTup), .BTdown(BTdown),
        .BTl(BTl), .BTr(BTr), .din(din), .dout(dout), .cursor(cursor),
        .changed(changed)
    );

    always #5 clk = ~clk;

    // Decimal view of a field: out-of-range or non-BCD snaps to the limit.
    function automatic logic [7:0] m_step(input logic [7:0] b, input bit up, input int mx);
        int t, u, v, nv;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        v = t * 10 + u;
        if (t > 9 || u > 9 || v > mx) nv = up ? 0 : mx;
        else if (up)                  nv = (v + 1) % (mx + 1);
        else                          nv = (v + mx) % (mx + 1);
        return 8'((nv / 10) * 16 + (nv % 10));
    endfunction

    int            m_mode;   // 0 idle, 1 load, 2 edit
    logic [8*N-1:0] m_dout;
    int            m_cur;
    bit            m_chg;
    bit [3:0]      m_prev;
    bit            m_run;
    int            m_age;

    always @(posedge clk) begin
        bit up_p, dn_p, l_p, r_p, step;
        int mx;
        up_p = BTup   && !m_prev[0];
        dn_p = BTdown && !m_prev[1];
        l_p  = BTl    && !m_prev[2];
        r_p  = BTr    && !m_prev[3];
        step = 1'b0;
        m_chg = 1'b0;
        if (!reset) begin
            m_mode = 0; m_dout = '0; m_cur = 0; m_run = 0; m_age = 0;
        end else if (!EN) begin
            m_mode = 0; m_cur = 0; m_run = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_dout = din; m_cur = 0; m_run = 0; m_mode = 2;
        end else begin
            if (BTup && BTdown) begin
                m_run = 0;
            end else if (up_p || dn_p) begin
                step = 1; m_run = 1; m_age = 0;
            end else if ((BTup != BTdown) && m_run) begin
                m_age++;
                if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0)) step = 1;
            end else begin
                m_run = 0;
            end
            if (step) begin
                mx = (m_cur == 0) ? FMAX : OMAX;
                m_dout[8*(N-1-m_cur) +: 8] = m_step(m_dout[8*(N-1-m_cur) +: 8], BTup, mx);
                m_chg = 1;
            end
            if (l_p != r_p) begin
                m_cur = (m_cur + (r_p ? 1 : N - 1)) % N;
                m_run = 0;
            end
        end
        m_prev = (!reset) ? 4'b0 : {BTr, BTl, BTdown, BTup};
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (dout !== m_dout || cursor !== 2'(m_cur) || changed !== m_chg) begin
                bad++;
                $display("FAIL model t=%0t: dout=%h cursor=%0d changed=%b want dout=%h cursor=%0d changed=%b",
                         $time, dout, cursor, changed, m_dout, m_cur, m_chg);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input bit u, input bit d, input bit l, input bit r);
        @(negedge clk);
        BTup = u; BTdown = d; BTl = l; BTr = r;
        @(posedge clk);
        #1;
    endtask

    task automatic reload(input logic [8*N-1:0] v);
        EN = 1'b0; din = v;
        tick(0, 0, 0, 0);
        EN = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    function automatic logic [8*N-1:0] rand_din();
        logic [8*N-1:0] v;
        int x;
        for (int f = 0; f < N; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                v[8*(N-1-f) +: 8] = 8'($urandom_range(0, 255));
            end else begin
                x = $urandom_range(0, (f == 0) ? FMAX : OMAX);
                v[8*(N-1-f) +: 8] = 8'((x / 10) * 16 + (x % 10));
            end
        end
        return v;
    endfunction

    initial begin
        logic [7:0] rep_exp [10];
        rep_exp = '{8'h09, 8'h09, 8'h09, 8'h09, 8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12};
        reset = 1'b0; EN = 1'b0; din = '0;
        BTup = 0; BTdown = 0; BTl = 0; BTr = 0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_cursor", 32'(cursor), 32'h0);
        chk("reset_changed", 32'(changed), 32'h0);
        chk_on = 1'b1;

        reset = 1'b1; din = 24'h235959; EN = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("load", 32'(dout), 32'h235959);
        tick(1, 0, 0, 0);
        chk("wrap_up_f0", 32'(dout), 32'h005959);
        chk("wrap_up_chg", 32'(changed), 32'h1);
        tick(0, 0, 0, 0);
        chk("chg_pulse", 32'(changed), 32'h0);

        tick(0, 0, 1, 0);
        chk("cur_wrap_l", 32'(cursor), 32'h2);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("f2_to_00", 32'(dout), 32'h005900);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("f2_down_wrap", 32'(dout), 32'h005959);
        chk("f2_down_chg", 32'(changed), 32'h1);
        tick(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 1, 0);
            chk("cur_seq", 32'(cursor), (k == 0) ? 32'h1 : (k == 1) ? 32'h0 : 32'h2);
            chk("move_nochg", 32'(changed), 32'h0);
            tick(0, 0, 0, 0);
        end

        reload(24'h000800);
        chk("reload", 32'(dout), 32'h000800);
        tick(0, 0, 0, 1);
        chk("cur_r", 32'(cursor), 32'h1);
        tick(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, 0, 0);
            chk("repeat_f1", 32'(dout[15:8]), 32'(rep_exp[k]));
        end
        tick(0, 0, 0, 0);

        tick(1, 1, 0, 0);
        chk("updn_dout", 32'(dout), 32'h001200);
        chk("updn_chg", 32'(changed), 32'h0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        chk("lr_cursor", 32'(cursor), 32'h1);
        tick(0, 0, 0, 0);

        reload(24'h121212);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        reset = 1'b0;
        tick(1, 0, 0, 0);
        chk("rst_mid_dout", 32'(dout), 32'h0);
        chk("rst_mid_cur", 32'(cursor), 32'h0);
        reset = 1'b1;
        tick(0, 0, 0, 0);
        chk("post_rst_idle", 32'(dout), 32'h0);
        tick(0, 0, 0, 0);
        chk("post_rst_load", 32'(dout), 32'h121212);

        reload(24'h007A00);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("bad_up", 32'(dout), 32'h000000);
        tick(0, 0, 0, 0);
        reload(24'h007A00);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("bad_down", 32'(dout), 32'h005900);
        tick(0, 0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) BTup   = ~BTup;
            if ($urandom_range(0, 5) == 0) BTdown = ~BTdown;
            if ($urandom_range(0, 7) == 0) BTl    = ~BTl;
            if ($urandom_range(0, 7) == 0) BTr    = ~BTr;
            if (EN) EN = ($urandom_range(0, 99) != 0);
            else    EN = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 9) == 0) din = rand_din();
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
